seq_branch_comparator: RTL
==========================

# seq_branch_comparator

Multi-cycle, parametrised successor to the core's combinational 32-bit comparator. It resolves RISC-V branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) by comparing operands MSB-first, CHUNK bits per cycle, behind valid/ready handshakes. It sits between the register-read stage and the branch-resolution logic of the core. It is intended for area-constrained builds and for widths beyond 32 bits.

## Interface
- WIDTH, 32, operand width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK, NCHUNK ≥ 1.
- EARLY_EXIT, 0, when 1 the block finishes as soon as a differing chunk is found.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request; high only in IDLE.
- i_a, i_b  in  WIDTH  operands (rs1, rs2).
- i_funct3  in  3  branch funct3; bit 1 selects unsigned compare.
- i_flush  in  1  synchronous abort (pipeline flush).
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  consumer accepts result.
- o_lt  out  1  a < b (signed or unsigned per funct3[1]).
- o_eq  out  1  a == b.
- o_taken  out  1  branch taken per funct3.
- o_err  out  1  funct3 was 010 or 011 (not a branch).
- o_busy  out  1  state is BUSY.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- Reset values: o_valid=0, o_lt=0, o_eq=0, o_taken=0, o_err=0, o_busy=0. o_ready=1 because the block is in IDLE. The internal chunk counter, the decided flag and the lt register are all reset to 0.
- IDLE: i_valid & o_ready & ~i_flush → capture the operands and funct3 into registers, clear the counter and the decided flag, go to BUSY.
- Signed handling: when funct3[1]=0, invert bit WIDTH-1 of both captured operands. The rest of the compare is purely unsigned. There is no magnitude negation.
- BUSY, one chunk per edge, processed MSB-first. Chunk k spans bits [WIDTH-1-k·CHUNK -: CHUNK].
  - If decided=0 and the two chunks differ: set decided=1 and lt = (a_chunk < b_chunk).
  - Once decided=1, later chunks are ignored.
  - Increment the counter each edge.
- BUSY exit: leave when the last chunk has been processed. With EARLY_EXIT=1, also leave on the edge that sets decided. In both cases go to DONE.
- DONE outputs:
  - o_valid=1.
  - o_eq = ~decided.
  - o_lt = lt.
  - o_taken: 000→eq, 001→~eq, 100/110→lt, 101/111→~lt, 010/011→0 with o_err=1.
- DONE: i_ready → IDLE and o_valid drops. Outputs are stable while o_valid=1 & ~i_ready.
- i_flush, in any state: next edge → IDLE and o_valid=0. Flush has priority over i_valid and i_ready. A flush in IDLE coincident with i_valid does not accept the request.
- Reset asserted mid-operation: the block immediately returns to IDLE with all outputs at their reset values, and the request is lost.

## Timing
- Accept edge = E0. Without early exit, o_valid rises after edge E_NCHUNK, i.e. NCHUNK cycles after accept (4 for defaults).
- With EARLY_EXIT=1, o_valid rises after edge E_(j+1), where j is the index of the first differing chunk. Latency is at least 1 cycle.
- Equal operands always take NCHUNK cycles.
- Back-to-back throughput: one result per NCHUNK+2 cycles. This is the accept cycle, NCHUNK BUSY edges, and one DONE cycle with i_ready high.
- o_ready is combinational from state only. It has no dependence on i_valid.

## Test plan
- Reset values: hold rst_n=0, then release. Required: o_ready=1, o_valid=0, o_lt=o_eq=o_taken=o_err=0.
- BLTU, defaults: a=0x0000_0001, b=0xFFFF_FFFF, funct3=110. Required: o_valid 4 cycles after accept, o_lt=1, o_eq=0, o_taken=1.
- BLT, same operands, funct3=100. Required: o_lt=0, o_taken=0. Then a=0xFFFF_FFFE (−2), b=0xFFFF_FFFF (−1), funct3=100. Required: o_lt=1, o_taken=1.
- BEQ/BNE, a=b=0x1234_5678:
  - funct3=000 → o_eq=1, o_taken=1.
  - funct3=001 → o_taken=0.
  - Latency is 4 cycles with EARLY_EXIT=0 and with EARLY_EXIT=1.
- EARLY_EXIT=1, a=0x8000_0000, b=0x0000_0000, funct3=111. Required: o_valid 1 cycle after accept, o_lt=0, o_taken=1.
- Flush, backpressure, illegal funct3:
  - i_flush in BUSY cycle 2 → IDLE next edge, o_valid never asserts.
  - With i_ready=0 for 5 cycles, outputs hold stable.
  - funct3=010 → o_err=1, o_taken=0.

Source files
------------

// File: rtl/seq_branch_comparator_if.sv
// Request/response bundle for the sequential branch comparator.
// The core side uses master and the comparator uses slave.
interface seq_branch_comparator_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [2:0]       i_funct3;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic             o_lt;
    logic             o_eq;
    logic             o_taken;
    logic             o_err;
    logic             o_busy;

    modport master (
        output i_valid, i_a, i_b, i_funct3, i_flush, i_ready,
        input  o_ready, o_valid, o_lt, o_eq, o_taken, o_err, o_busy
    );

    modport slave (
        input  i_valid, i_a, i_b, i_funct3, i_flush, i_ready,
        output o_ready, o_valid, o_lt, o_eq, o_taken, o_err, o_busy
    );
endinterface

// File: rtl/seq_branch_comparator.sv
// Multi-cycle RISC-V branch comparator. It compares the operands MSB-first,
// CHUNK bits per cycle, behind valid/ready handshakes.
module seq_branch_comparator #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK      = 8,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_branch_comparator_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             lt_q, lt_d;

    logic o_valid_q, o_valid_d;
    logic o_lt_q, o_lt_d;
    logic o_eq_q, o_eq_d;
    logic o_taken_q, o_taken_d;
    logic o_err_q, o_err_d;
    logic o_busy_q, o_busy_d;

    logic             accept_c;
    logic             last_c;
    logic             set_dec_c;
    logic [CHUNK-1:0] a_chunk_c;
    logic [CHUNK-1:0] b_chunk_c;
    logic [WIDTH-1:0] sign_mask_c;

    // The operands shift left each BUSY edge, so the active chunk is always at the top.
    assign a_chunk_c   = a_q[WIDTH-1 -: CHUNK];
    assign b_chunk_c   = b_q[WIDTH-1 -: CHUNK];
    assign accept_c    = (state_q == ST_IDLE) && bus.i_valid && !bus.i_flush;
    assign last_c      = (cnt_q == LAST_CNT);
    assign set_dec_c   = (state_q == ST_BUSY) && !decided_q && (a_chunk_c != b_chunk_c);
    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign sign_mask_c = bus.i_funct3[1] ? '0 : MSB_MASK;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_valid) state_d = ST_BUSY;
            ST_BUSY: if (last_c || (EARLY_EXIT && set_dec_c)) state_d = ST_DONE;
            ST_DONE: if (bus.i_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.i_flush) begin
            state_d = ST_IDLE;
        end
    end

    // Operand capture and chunk-serial compare
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        funct3_d  = funct3_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        lt_d      = lt_q;
        if (accept_c) begin
            a_d       = bus.i_a ^ sign_mask_c;
            b_d       = bus.i_b ^ sign_mask_c;
            funct3_d  = bus.i_funct3;
            cnt_d     = '0;
            decided_d = 1'b0;
            lt_d      = 1'b0;
        end else if (state_q == ST_BUSY) begin
            a_d   = a_q << CHUNK;
            b_d   = b_q << CHUNK;
            cnt_d = cnt_q + CNT_W'(1);
            if (set_dec_c) begin
                decided_d = 1'b1;
                lt_d      = (a_chunk_c < b_chunk_c);
            end
        end
    end

    // Output logic, registered so the outputs are valid from the edge that enters DONE
    always_comb begin
        o_valid_d = 1'b0;
        o_lt_d    = 1'b0;
        o_eq_d    = 1'b0;
        o_taken_d = 1'b0;
        o_err_d   = 1'b0;
        o_busy_d  = (state_d == ST_BUSY);
        if (state_d == ST_DONE) begin
            o_valid_d = 1'b1;
            o_eq_d    = !decided_d;
            o_lt_d    = lt_d;
            o_err_d   = (funct3_d[2:1] == 2'b01);
            case (funct3_d)
                3'b000:          o_taken_d = !decided_d;
                3'b001:          o_taken_d = decided_d;
                3'b100, 3'b110:  o_taken_d = lt_d;
                3'b101, 3'b111:  o_taken_d = !lt_d;
                default:         o_taken_d = 1'b0;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            funct3_q  <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            o_valid_q <= 1'b0;
            o_lt_q    <= 1'b0;
            o_eq_q    <= 1'b0;
            o_taken_q <= 1'b0;
            o_err_q   <= 1'b0;
            o_busy_q  <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            funct3_q  <= funct3_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            lt_q      <= lt_d;
            o_valid_q <= o_valid_d;
            o_lt_q    <= o_lt_d;
            o_eq_q    <= o_eq_d;
            o_taken_q <= o_taken_d;
            o_err_q   <= o_err_d;
            o_busy_q  <= o_busy_d;
        end
    end

    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_valid = o_valid_q;
    assign bus.o_lt    = o_lt_q;
    assign bus.o_eq    = o_eq_q;
    assign bus.o_taken = o_taken_q;
    assign bus.o_err   = o_err_q;
    assign bus.o_busy  = o_busy_q;

endmodule
